// File: rtl/axi_mem_ecc_pkg.sv
// Shared SECDED (72,64) definitions: check-bit width, controller states,
// Hamming position map and the check-bit encoder.
package axi_mem_ecc_pkg;

   localparam int EW = 8;

   typedef enum logic [0:0] {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_e;

   // {overall parity mismatch, Hamming syndrome}
   typedef logic [EW-1:0] syndrome_t;

   // Codeword position (1..71) of data bit idx; powers of two hold check bits.
   function automatic logic [6:0] data_pos(input int idx);
      logic [6:0] pos;
      logic [6:0] pv;
      int         n;
      pos = '0;
      n   = 0;
      for (int p = 1; p < 72; p++) begin
         pv = 7'(p);
         if ((pv & (pv - 7'd1)) != 7'd0) begin
            if (n == idx) pos = pv;
            n++;
         end
      end
      return pos;
   endfunction

   function automatic logic [EW-2:0] hamming(input logic [63:0] d);
      logic [EW-2:0] h;
      logic [5:0]    di;
      logic [6:0]    pv;
      h  = '0;
      di = '0;
      for (int p = 1; p < 72; p++) begin
         pv = 7'(p);
         if ((pv & (pv - 7'd1)) != 7'd0) begin
            h  = h ^ (pv & {7{d[di]}});
            di = di + 6'd1;
         end
      end
      return h;
   endfunction

   // Top check bit makes the whole 72-bit word even parity.
   function automatic logic [EW-1:0] encode(input logic [63:0] d);
      logic [EW-2:0] h;
      h = hamming(d);
      return {^{h, d}, h};
   endfunction

endpackage

// File: rtl/axi_mem_ecc_ctrl_if.sv
// Upstream memory request/response bus of the ECC controller.
interface axi_mem_ecc_ctrl_if #(
   parameter int AW = 12,
   parameter int DW = 64
);
   logic          req_cs;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [DW-1:0] resp_rdata;

   modport master (
      output req_cs, req_we, req_addr, req_wdata,
      input  resp_rdata
   );

   modport slave (
      input  req_cs, req_we, req_addr, req_wdata,
      output resp_rdata
   );
endinterface

// File: rtl/axi_mem_ecc_secded_dec.sv
// SECDED (72,64) decoder: syndrome, single-bit correction, SBE/DBE flags.
module axi_mem_ecc_secded_dec
   import axi_mem_ecc_pkg::*;
(
   input  logic [71:0] i_code,
   output logic [63:0] o_data,
   output logic        o_sbe,
   output logic        o_dbe
);
   syndrome_t w_syn;

   assign w_syn = {^i_code, hamming(i_code[63:0]) ^ i_code[70:64]};

   // Odd overall parity with an in-range position is one flipped bit; a check-bit
   // position leaves the data untouched.
   assign o_sbe = w_syn[7] & (w_syn[6:0] < 7'd72);
   assign o_dbe = (~w_syn[7] & (|w_syn[6:0])) | (w_syn[7] & (w_syn[6:0] >= 7'd72));

   for (genvar gi = 0; gi < 64; gi++) begin : g_fix
      localparam logic [6:0] POS = data_pos(gi);
      assign o_data[gi] = i_code[gi] ^ (o_sbe & (w_syn[6:0] == POS));
   end
endmodule

// File: rtl/axi_mem_ecc_ctrl.sv
// ECC SRAM controller: zeroizing INIT walk, pass-through requests in READY,
// one-cycle corrected reads and saturating error counters.
module axi_mem_ecc_ctrl #(
   parameter int AW = 12,
   parameter int DW = 64,
   parameter int EW = 8
) (
   input  logic               clk,
   input  logic               rst,
   axi_mem_ecc_ctrl_if.slave  req_if,
   output logic               sram_cs,
   output logic               sram_we,
   output logic [AW-1:0]      sram_addr,
   output logic [DW+EW-1:0]   sram_wdata,
   input  logic [DW+EW-1:0]   sram_rdata,
   input  logic               init_req,
   output logic               init_done,
   output logic               req_drop,
   output logic [15:0]        sbe_cnt,
   output logic [15:0]        dbe_cnt,
   output logic [AW-1:0]      err_addr,
   input  logic               cnt_clr
);
   import axi_mem_ecc_pkg::*;

   state_e        r_state;
   logic [AW-1:0] r_init_addr;
   logic          r_drop;
   logic          r_rd_vld_p1;
   logic [AW-1:0] r_rd_addr_p1;
   logic [15:0]   r_sbe_cnt;
   logic [15:0]   r_dbe_cnt;
   logic [AW-1:0] r_err_addr;

   logic          w_ready;
   logic          w_rd_p0;
   logic          w_last;
   logic [DW-1:0] w_dec_data;
   logic          w_sbe;
   logic          w_dbe;
   logic          w_sbe_ev;
   logic          w_dbe_ev;

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign w_ready = (r_state == S_READY);
   assign w_rd_p0 = w_ready & req_if.req_cs & ~req_if.req_we;
   assign w_last  = (r_init_addr == {AW{1'b1}});

   // Strobes are gated by rst so nothing reaches the macro while held in reset.
   assign sram_cs    = ~rst & (w_ready ? req_if.req_cs : 1'b1);
   assign sram_we    = w_ready ? req_if.req_we : 1'b1;
   assign sram_addr  = w_ready ? req_if.req_addr : r_init_addr;
   assign sram_wdata = w_ready ? {encode(req_if.req_wdata), req_if.req_wdata}
                               : {encode({DW{1'b0}}), {DW{1'b0}}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_init_addr <= '0;
         r_drop      <= 1'b0;
         r_rd_vld_p1 <= 1'b0;
      end else begin
         r_drop      <= ~w_ready & req_if.req_cs;
         r_rd_vld_p1 <= w_rd_p0;
         if (init_req) begin
            r_state     <= S_INIT;
            r_init_addr <= '0;
         end else if (!w_ready) begin
            r_init_addr <= r_init_addr + 1'b1;
            if (w_last) r_state <= S_READY;
         end
      end
   end

   // p0 -> p1: read address follows the read-pending flag into the data cycle
   always_ff @(posedge clk) begin
      if (w_rd_p0) r_rd_addr_p1 <= req_if.req_addr;
   end

   axi_mem_ecc_secded_dec u_dec (
      .i_code (sram_rdata),
      .o_data (w_dec_data),
      .o_sbe  (w_sbe),
      .o_dbe  (w_dbe)
   );

   assign w_sbe_ev = r_rd_vld_p1 & w_sbe;
   assign w_dbe_ev = r_rd_vld_p1 & w_dbe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sbe_cnt  <= '0;
         r_dbe_cnt  <= '0;
         r_err_addr <= '0;
      end else if (cnt_clr) begin
         r_sbe_cnt  <= '0;
         r_dbe_cnt  <= '0;
         r_err_addr <= '0;
      end else begin
         if (w_sbe_ev) r_sbe_cnt <= sat_inc(r_sbe_cnt);
         if (w_dbe_ev) r_dbe_cnt <= sat_inc(r_dbe_cnt);
         if (w_sbe_ev | w_dbe_ev) r_err_addr <= r_rd_addr_p1;
      end
   end

   assign req_if.resp_rdata = r_rd_vld_p1 ? w_dec_data : '0;
   assign init_done         = w_ready;
   assign req_drop          = r_drop;
   assign sbe_cnt           = r_sbe_cnt;
   assign dbe_cnt           = r_dbe_cnt;
   assign err_addr          = r_err_addr;
endmodule

// File: tb/tb_axi_mem_ecc_ctrl.sv
// Directed bench for axi_mem_ecc_ctrl (AW=4) with a behavioural SRAM that can
// corrupt selected bits of one address on read.
module tb_axi_mem_ecc_ctrl;
   localparam logic [63:0] D_A     = 64'hDEAD_BEEF_0123_4567;
   localparam logic [63:0] D_B     = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D_B_RAW = 64'h0123_4467_89AB_CDE7;
   localparam logic [63:0] D_2     = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] D_3     = 64'h8000_0000_0000_0001;

   logic        clk;
   logic        rst;
   logic        sram_cs, sram_we;
   logic [3:0]  sram_addr;
   logic [71:0] sram_wdata;
   logic [71:0] sram_rdata;
   logic        init_req, init_done, req_drop, cnt_clr;
   logic [15:0] sbe_cnt, dbe_cnt;
   logic [3:0]  err_addr;

   logic [71:0] mem [16];
   logic [71:0] flip_mask;
   logic [3:0]  flip_addr;

   int n_vec;
   int n_bad;

   axi_mem_ecc_ctrl_if #(.AW(4), .DW(64)) bus ();

   axi_mem_ecc_ctrl #(.AW(4), .DW(64), .EW(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_if     (bus),
      .sram_cs    (sram_cs),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .init_req   (init_req),
      .init_done  (init_done),
      .req_drop   (req_drop),
      .sbe_cnt    (sbe_cnt),
      .dbe_cnt    (dbe_cnt),
      .err_addr   (err_addr),
      .cnt_clr    (cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else sram_rdata <= mem[sram_addr] ^ ((sram_addr == flip_addr) ? flip_mask : 72'd0);
      end
   end

   task automatic do_read(input logic [3:0] a, output logic [63:0] d);
      bus.req_cs   = 1'b1;
      bus.req_we   = 1'b0;
      bus.req_addr = a;
      @(negedge clk);
      bus.req_cs = 1'b0;
      #1;
      d = bus.resp_rdata;
   endtask

   task automatic test_reset();
      bus.req_cs = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_vec++;
      if (sram_cs !== 1'b0) begin n_bad++; $display("FAIL reset_sram_cs: got %b want 0", sram_cs); end
      n_vec++;
      if ({init_done, req_drop, sbe_cnt, dbe_cnt, err_addr, bus.resp_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got done=%b drop=%b sbe=%h dbe=%h ea=%h rd=%h want all 0",
                  init_done, req_drop, sbe_cnt, dbe_cnt, err_addr, bus.resp_rdata);
      end
      bus.req_cs = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_init_walk();
      for (int k = 0; k < 16; k++) begin
         bus.req_cs   = (k == 3);
         bus.req_we   = 1'b0;
         bus.req_addr = 4'd9;
         #1;
         n_vec++;
         if ({sram_cs, sram_we, sram_addr, sram_wdata} !== {1'b1, 1'b1, 4'(k), 72'd0}) begin
            n_bad++;
            $display("FAIL init_walk[%0d]: got cs=%b we=%b a=%h wd=%h want cs=1 we=1 a=%h wd=0",
                     k, sram_cs, sram_we, sram_addr, sram_wdata, 4'(k));
         end
         n_vec++;
         if (init_done !== 1'b0) begin n_bad++; $display("FAIL init_done_low[%0d]: got %b want 0", k, init_done); end
         if (k == 4) begin
            n_vec++;
            if (req_drop !== 1'b1) begin n_bad++; $display("FAIL req_drop_pulse: got %b want 1", req_drop); end
         end
         if (k == 3 || k == 5) begin
            n_vec++;
            if (req_drop !== 1'b0) begin n_bad++; $display("FAIL req_drop_idle[%0d]: got %b want 0", k, req_drop); end
         end
         @(negedge clk);
      end
      bus.req_cs = 1'b0;
      #1;
      n_vec++;
      if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done_cycle17: got %b want 1", init_done); end
   endtask

   task automatic test_write_read();
      logic [63:0] d;
      bus.req_cs    = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 4'd5;
      bus.req_wdata = D_A;
      #1;
      n_vec++;
      if ({sram_cs, sram_we, sram_addr, sram_wdata[63:0]} !== {1'b1, 1'b1, 4'd5, D_A}) begin
         n_bad++;
         $display("FAIL write_passthru: got cs=%b we=%b a=%h d=%h want cs=1 we=1 a=5 d=%h",
                  sram_cs, sram_we, sram_addr, sram_wdata[63:0], D_A);
      end
      @(negedge clk);
      bus.req_cs = 1'b0;
      bus.req_we = 1'b0;
      do_read(4'd5, d);
      n_vec++;
      if (d !== D_A) begin n_bad++; $display("FAIL read_back: got %h want %h", d, D_A); end
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.resp_rdata !== 64'd0) begin n_bad++; $display("FAIL resp_idle: got %h want 0", bus.resp_rdata); end
      n_vec++;
      if ({sbe_cnt, dbe_cnt} !== 32'd0) begin n_bad++; $display("FAIL clean_counts: got sbe=%h dbe=%h want 0 0", sbe_cnt, dbe_cnt); end
   endtask

   task automatic test_sbe();
      logic [63:0] d;
      flip_addr = 4'd5;
      flip_mask = 72'd1 << 13;
      do_read(4'd5, d);
      n_vec++;
      if (d !== D_A) begin n_bad++; $display("FAIL sbe_data_bit13: got %h want %h", d, D_A); end
      @(negedge clk);
      #1;
      n_vec++;
      if ({sbe_cnt, dbe_cnt, err_addr} !== {16'd1, 16'd0, 4'd5}) begin
         n_bad++;
         $display("FAIL sbe_count: got sbe=%h dbe=%h ea=%h want 1 0 5", sbe_cnt, dbe_cnt, err_addr);
      end
      flip_mask = 72'd1 << 66;
      do_read(4'd5, d);
      n_vec++;
      if (d !== D_A) begin n_bad++; $display("FAIL sbe_data_chk66: got %h want %h", d, D_A); end
      @(negedge clk);
      #1;
      n_vec++;
      if (sbe_cnt !== 16'd2) begin n_bad++; $display("FAIL sbe_count_chk: got %h want 2", sbe_cnt); end
      flip_mask = '0;
   endtask

   task automatic test_dbe();
      logic [63:0] d;
      bus.req_cs    = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 4'd7;
      bus.req_wdata = D_B;
      @(negedge clk);
      bus.req_cs = 1'b0;
      bus.req_we = 1'b0;
      flip_addr = 4'd7;
      flip_mask = (72'd1 << 3) | (72'd1 << 40);
      do_read(4'd7, d);
      n_vec++;
      if (d !== D_B_RAW) begin n_bad++; $display("FAIL dbe_raw_data: got %h want %h", d, D_B_RAW); end
      @(negedge clk);
      #1;
      n_vec++;
      if ({sbe_cnt, dbe_cnt, err_addr} !== {16'd2, 16'd1, 4'd7}) begin
         n_bad++;
         $display("FAIL dbe_count: got sbe=%h dbe=%h ea=%h want 2 1 7", sbe_cnt, dbe_cnt, err_addr);
      end
      flip_mask = '0;
   endtask

   task automatic test_back_to_back();
      bus.req_cs    = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 4'd2;
      bus.req_wdata = D_2;
      @(negedge clk);
      bus.req_addr  = 4'd3;
      bus.req_wdata = D_3;
      @(negedge clk);
      bus.req_we   = 1'b0;
      bus.req_addr = 4'd2;
      #1;
      n_vec++;
      if ({sram_cs, sram_we, sram_addr} !== {1'b1, 1'b0, 4'd2}) begin
         n_bad++;
         $display("FAIL b2b_read_strobe: got cs=%b we=%b a=%h want 1 0 2", sram_cs, sram_we, sram_addr);
      end
      @(negedge clk);
      bus.req_addr = 4'd3;
      #1;
      n_vec++;
      if (bus.resp_rdata !== D_2) begin n_bad++; $display("FAIL b2b_first: got %h want %h", bus.resp_rdata, D_2); end
      @(negedge clk);
      bus.req_cs = 1'b0;
      #1;
      n_vec++;
      if (bus.resp_rdata !== D_3) begin n_bad++; $display("FAIL b2b_second: got %h want %h", bus.resp_rdata, D_3); end
      @(negedge clk);
      #1;
      n_vec++;
      if (bus.resp_rdata !== 64'd0) begin n_bad++; $display("FAIL b2b_idle: got %h want 0", bus.resp_rdata); end
   endtask

   task automatic test_init_req();
      logic [63:0] d;
      int          low;
      bus.req_cs   = 1'b1;
      bus.req_we   = 1'b0;
      bus.req_addr = 4'd3;
      init_req     = 1'b1;
      @(negedge clk);
      bus.req_cs = 1'b0;
      init_req   = 1'b0;
      #1;
      n_vec++;
      if (bus.resp_rdata !== D_3) begin n_bad++; $display("FAIL inflight_read: got %h want %h", bus.resp_rdata, D_3); end
      n_vec++;
      if ({sram_cs, sram_we, sram_addr} !== {1'b1, 1'b1, 4'd0}) begin
         n_bad++;
         $display("FAIL reinit_start: got cs=%b we=%b a=%h want 1 1 0", sram_cs, sram_we, sram_addr);
      end
      low = 0;
      while (init_done !== 1'b1 && low < 40) begin
         low++;
         @(negedge clk);
         #1;
      end
      n_vec++;
      if (low != 16) begin n_bad++; $display("FAIL reinit_low_cycles: got %0d want 16", low); end
      for (int a = 0; a < 16; a++) begin
         do_read(4'(a), d);
         n_vec++;
         if (d !== 64'd0) begin n_bad++; $display("FAIL zeroized[%0d]: got %h want 0", a, d); end
      end
   endtask

   task automatic test_init_restart();
      int low;
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      n_vec++;
      if (sram_addr !== 4'd5) begin n_bad++; $display("FAIL walk_progress: got %h want 5", sram_addr); end
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      #1;
      n_vec++;
      if ({sram_cs, sram_addr, init_done} !== {1'b1, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL walk_restart: got cs=%b a=%h done=%b want 1 0 0", sram_cs, sram_addr, init_done);
      end
      low = 0;
      while (init_done !== 1'b1 && low < 40) begin
         low++;
         @(negedge clk);
         #1;
      end
      n_vec++;
      if (low != 16) begin n_bad++; $display("FAIL restart_low_cycles: got %0d want 16", low); end
   endtask

   task automatic test_saturation();
      logic [63:0] d;
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      #1;
      n_vec++;
      if ({sbe_cnt, dbe_cnt, err_addr} !== '0) begin
         n_bad++;
         $display("FAIL cnt_clr: got sbe=%h dbe=%h ea=%h want 0 0 0", sbe_cnt, dbe_cnt, err_addr);
      end
      flip_addr    = 4'd5;
      flip_mask    = 72'd1 << 13;
      bus.req_cs   = 1'b1;
      bus.req_we   = 1'b0;
      bus.req_addr = 4'd5;
      repeat (65535) @(negedge clk);
      bus.req_cs = 1'b0;
      @(negedge clk);
      #1;
      n_vec++;
      if ({sbe_cnt, err_addr} !== {16'hFFFF, 4'd5}) begin
         n_bad++;
         $display("FAIL sbe_reach_max: got sbe=%h ea=%h want ffff 5", sbe_cnt, err_addr);
      end
      do_read(4'd5, d);
      do_read(4'd5, d);
      @(negedge clk);
      #1;
      n_vec++;
      if (sbe_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sbe_saturate: got %h want ffff", sbe_cnt); end
      do_read(4'd5, d);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      #1;
      n_vec++;
      if ({sbe_cnt, err_addr} !== {16'd0, 4'd0}) begin
         n_bad++;
         $display("FAIL clr_beats_sbe: got sbe=%h ea=%h want 0 0", sbe_cnt, err_addr);
      end
      flip_mask = '0;
   endtask

   task automatic test_reset_mid();
      logic [63:0] d;
      flip_addr    = 4'd7;
      flip_mask    = (72'd1 << 3) | (72'd1 << 40);
      bus.req_cs   = 1'b1;
      bus.req_we   = 1'b0;
      bus.req_addr = 4'd7;
      @(negedge clk);
      bus.req_cs = 1'b0;
      rst        = 1'b1;
      #1;
      n_vec++;
      if ({sram_cs, init_done, bus.resp_rdata} !== {1'b0, 1'b0, 64'd0}) begin
         n_bad++;
         $display("FAIL midread_reset: got cs=%b done=%b rd=%h want 0 0 0", sram_cs, init_done, bus.resp_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if ({sram_cs, sram_addr} !== {1'b1, 4'd0}) begin
         n_bad++;
         $display("FAIL walk_after_reset: got cs=%b a=%h want 1 0", sram_cs, sram_addr);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({dbe_cnt, sbe_cnt, err_addr} !== '0) begin
         n_bad++;
         $display("FAIL no_event_after_reset: got dbe=%h sbe=%h ea=%h want 0 0 0", dbe_cnt, sbe_cnt, err_addr);
      end
      flip_mask = '0;
      d = '0;
   endtask

   initial begin
      n_vec         = 0;
      n_bad         = 0;
      rst           = 1'b1;
      init_req      = 1'b0;
      cnt_clr       = 1'b0;
      flip_mask     = '0;
      flip_addr     = '0;
      bus.req_cs    = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      test_reset();
      test_init_walk();
      test_write_read();
      test_sbe();
      test_dbe();
      test_back_to_back();
      test_init_req();
      test_init_restart();
      test_saturation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
      $fatal(1);
   end
endmodule

// File: doc/axi_mem_ecc_ctrl.md
AXI_MEM_ECC_CTRL -- requirements
Module: axi_mem_ecc_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12, word-address width (depth = 2**AW words).
REQ-002 SHALL have parameter DW, default 64, data width; only 64 is legal.
REQ-003 SHALL have parameter EW, default 8, SECDED check-bit width for (72,64).
REQ-004 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_cs  input  1  upstream memory request strobe.
REQ-007 SHALL have port req_we  input  1  request is write.
REQ-008 SHALL have port req_addr  input  AW  word address.
REQ-009 SHALL have port req_wdata  input  DW  write data.
REQ-010 SHALL have port resp_rdata  output  DW  corrected read data.
REQ-011 SHALL have port sram_cs / sram_we  output  1 each  SRAM macro strobes.
REQ-012 SHALL have port sram_addr  output  AW  SRAM address.
REQ-013 SHALL have port sram_wdata  output  DW+EW  data plus check bits.
REQ-014 SHALL have port sram_rdata  input  DW+EW  SRAM read data, valid 1 cycle after read strobe.
REQ-015 SHALL have port init_req  input  1  pulse: re-zeroize memory.
REQ-016 SHALL have port init_done  output  1  high when memory initialized and requests accepted.
REQ-017 SHALL have port req_drop  output  1  1-cycle pulse: request discarded during INIT.
REQ-018 SHALL have port sbe_cnt / dbe_cnt  output  16 each  saturating single/double-bit error counts.
REQ-019 SHALL have port err_addr  output  AW  address of most recent SBE or DBE.
REQ-020 SHALL have port cnt_clr  input  1  pulse: clear counters and err_addr.

Function
REQ-021 SHALL implement FSM states INIT and READY; INIT entered on reset and on init_req in READY.
REQ-022 In INIT SHALL write one word per cycle: addr counter 0..2**AW-1, data 0, valid check bits.
REQ-023 After writing address 2**AW-1 SHALL move to READY next cycle; init_done asserts in READY only.
REQ-024 init_req received while in INIT SHALL restart the counter at 0.
REQ-025 In INIT, req_cs SHALL not reach the SRAM; req_drop pulses the following cycle.
REQ-026 In READY, sram_cs/we/addr SHALL equal req_cs/we/addr combinationally (zero added latency).
REQ-027 Writes SHALL store {encode(req_wdata), req_wdata}; encoder purely combinational.
REQ-028 Read latency SHALL be exactly 1 cycle: resp_rdata is the decoded sram_rdata in the cycle after req_cs&!req_we.
REQ-029 SHALL register a read-pending flag and the read address; error events are qualified by the flag only.
REQ-030 SBE: resp_rdata SHALL carry the corrected data; sbe_cnt increments; err_addr updated.
REQ-031 DBE: resp_rdata SHALL carry raw data bits; dbe_cnt increments; err_addr updated.
REQ-032 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-033 cnt_clr coincident with an error event: clear wins; the event is not counted.
REQ-034 Read in flight at an init_req edge SHALL still return decoded data the next cycle.
REQ-035 resp_rdata SHALL be 0 when no read is pending.

Reset
REQ-036 While rst is high: state INIT, addr counter 0, init_done 0, req_drop 0, counters 0, err_addr 0, read-pending 0.
REQ-037 sram_cs SHALL be 0 while rst is high; the INIT walk starts on the first clock after deassertion.
REQ-038 Reset asserted mid-INIT or mid-read SHALL abandon the operation without an error event.

Structure
REQ-039 Package axi_mem_ecc_pkg SHALL hold: EW constant, FSM state enum, encode function, syndrome type.
REQ-040 A single sub-module axi_mem_ecc_secded_dec SHALL compute syndrome, corrected data and the sbe/dbe flags.

Verification
REQ-041 Reset release, AW=4 -> 16 zero-writes on consecutive cycles, init_done high on cycle 17, req_drop for any request issued meanwhile.
REQ-042 Write 0xDEAD_BEEF_0123_4567 to addr 5, read it back -> same data 1 cycle later, counters 0.
REQ-043 Flip SRAM bit 13 at addr 5, read -> corrected data, sbe_cnt=1, err_addr=5.
REQ-044 Flip bits 3 and 40 at addr 7, read -> dbe_cnt=1, err_addr=7, raw data returned.
REQ-045 Preload sbe_cnt=0xFFFF, inject SBE -> count stays 0xFFFF; cnt_clr in the same cycle as an SBE -> count 0.
REQ-046 init_req in READY after writes -> all addresses read back 0, init_done low for 2**AW cycles.
